e203_exu_flush_ctrl: RTL

Registered flush arbiter between the commit-stage flush sources and the IFU flush port. It takes flush requests from the exception/interrupt unit and the branch-resolve unit, grants one per cycle with exception priority, and latches the adder operands. It then holds a stable `pipe_flush_req` to the IFU until `pipe_flush_ack`. This cuts the combinational path from commit to IFU and gives the IFU a glitch-free flush payload.

---
 rtl/e203_exu_flush_ctrl_pkg.sv | 19 +
 rtl/e203_exu_flush_pld_reg.sv | 25 ++
 rtl/e203_exu_flush_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/e203_exu_flush_ctrl_pkg.sv
// Shared definitions for the EXU flush arbiter.
// Holds the flush FSM state encoding, the flush-source encoding and the
// default operand/PC width, which is tied to the core PC size.
package e203_exu_flush_ctrl_pkg;

    localparam int E203_PC_SIZE = 32;
    localparam int FLUSH_PC_W   = E203_PC_SIZE;

    typedef enum logic {
        FLUSH_IDLE = 1'b0,
        FLUSH_HOLD = 1'b1
    } flush_state_e;

    typedef enum logic {
        FLUSH_SRC_EXCP = 1'b0,
        FLUSH_SRC_BRCH = 1'b1
    } flush_src_e;

endpackage

// File: rtl/e203_exu_flush_pld_reg.sv
// Enable-load payload register for the flush arbiter.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears to 0)
//   ld_en      : load d into q this cycle
//   d          : next payload value
//   q          : held payload value
module e203_exu_flush_pld_reg #(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ld_en,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (ld_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/e203_exu_flush_ctrl.sv
// Registered flush arbiter between the commit-stage flush sources and the
// IFU flush port. Grants at most one flush source per cycle (exception over
// branch), latches the adder operands, and holds a stable pipe_flush_req
// plus payload until the IFU acknowledges it. A held branch flush may be
// replaced by an exception flush; a held exception flush is never replaced.
//
// Optional feature macro: E203_FLUSH_PC_EN adds the *_flush_pc inputs and
// the held pipe_flush_pc register/output.
//
// Ports:
//   clk, rst_n                      : clock, asynchronous active-low reset
//   excp_flush_req/ack/op1/op2[/pc] : exception/IRQ flush source
//   brch_flush_req/ack/op1/op2[/pc] : branch/mret/dret/fence.i flush source
//   pipe_flush_req/ack              : registered flush handshake to the IFU
//   pipe_flush_add_op1/op2[/pc]     : held flush payload
//   flush_src                       : 0 = exception, 1 = branch
//   flush_pulse                     : flush accepted by the IFU this cycle
//   preempt_evt                     : held branch flush replaced by exception
//   busy                            : a flush is being held
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | no flush held; next request is granted immediately
// HOLD  | a flush is presented to the IFU and frozen until pipe_flush_ack
module e203_exu_flush_ctrl
    import e203_exu_flush_ctrl_pkg::*;
#(
    parameter int PC_W = E203_PC_SIZE
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            excp_flush_req,
    output logic            excp_flush_ack,
    input  logic [PC_W-1:0] excp_flush_op1,
    input  logic [PC_W-1:0] excp_flush_op2,
`ifdef E203_FLUSH_PC_EN
    input  logic [PC_W-1:0] excp_flush_pc,
`endif

    input  logic            brch_flush_req,
    output logic            brch_flush_ack,
    input  logic [PC_W-1:0] brch_flush_op1,
    input  logic [PC_W-1:0] brch_flush_op2,
`ifdef E203_FLUSH_PC_EN
    input  logic [PC_W-1:0] brch_flush_pc,
`endif

    output logic            pipe_flush_req,
    input  logic            pipe_flush_ack,
    output logic [PC_W-1:0] pipe_flush_add_op1,
    output logic [PC_W-1:0] pipe_flush_add_op2,
`ifdef E203_FLUSH_PC_EN
    output logic [PC_W-1:0] pipe_flush_pc,
`endif

    output logic            flush_src,
    output logic            flush_pulse,
    output logic            preempt_evt,
    output logic            busy
);

    flush_state_e state_q, state_nxt;
    flush_src_e   src_q, src_nxt;
    logic         hold;
    logic         slot_free;
    logic         load;

    assign hold = (state_q == FLUSH_HOLD);

    // A new grant is possible when nothing is held or the held flush is
    // completing this cycle.
    assign slot_free = !hold || pipe_flush_ack;

    always_comb begin
        state_nxt      = state_q;
        src_nxt        = src_q;
        excp_flush_ack = 1'b0;
        brch_flush_ack = 1'b0;
        preempt_evt    = 1'b0;

        if (slot_free) begin
            if (excp_flush_req) begin
                excp_flush_ack = 1'b1;
                src_nxt        = FLUSH_SRC_EXCP;
                state_nxt      = FLUSH_HOLD;
            end else if (brch_flush_req) begin
                brch_flush_ack = 1'b1;
                src_nxt        = FLUSH_SRC_BRCH;
                state_nxt      = FLUSH_HOLD;
            end else begin
                state_nxt      = FLUSH_IDLE;
            end
        end else if ((src_q == FLUSH_SRC_BRCH) && excp_flush_req) begin
            // Exception supersedes a branch flush the IFU has not taken yet.
            excp_flush_ack = 1'b1;
            preempt_evt    = 1'b1;
            src_nxt        = FLUSH_SRC_EXCP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FLUSH_IDLE;
            src_q   <= FLUSH_SRC_EXCP;
        end else begin
            state_q <= state_nxt;
            src_q   <= src_nxt;
        end
    end

    assign load = excp_flush_ack || brch_flush_ack;

    logic [PC_W-1:0] op1_d, op2_d;
    assign op1_d = excp_flush_ack ? excp_flush_op1 : brch_flush_op1;
    assign op2_d = excp_flush_ack ? excp_flush_op2 : brch_flush_op2;

    e203_exu_flush_pld_reg #(.PC_W(PC_W)) u_op1_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_en (load),
        .d     (op1_d),
        .q     (pipe_flush_add_op1)
    );

    e203_exu_flush_pld_reg #(.PC_W(PC_W)) u_op2_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_en (load),
        .d     (op2_d),
        .q     (pipe_flush_add_op2)
    );

`ifdef E203_FLUSH_PC_EN
    logic [PC_W-1:0] pc_d;
    assign pc_d = excp_flush_ack ? excp_flush_pc : brch_flush_pc;

    e203_exu_flush_pld_reg #(.PC_W(PC_W)) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .ld_en (load),
        .d     (pc_d),
        .q     (pipe_flush_pc)
    );
`endif

    assign busy           = hold;
    assign pipe_flush_req = hold;
    assign flush_src      = src_q;
    assign flush_pulse    = hold && pipe_flush_ack;

endmodule
